// File: rtl/hash_arbiter.sv
// Round-robin front end that time-shares one byte-stream hash core among NREQ requesters.
// Optional stall timeout with zero-fill flush is enabled by defining HASH_ARB_TIMEOUT_EN.
module hash_arbiter #(
  parameter int NREQ    = 2,
  parameter int LEN_W   = 64,
  parameter int DIG_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     req_byte,
  input  logic [NREQ-1:0]       req_byte_valid,
  output logic [NREQ-1:0]       byte_ready,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [DIG_W-1:0]      digest_out,
  output logic                  busy,
  output logic [NREQ-1:0]       err,
  output logic                  core_m_valid,
  output logic [LEN_W-1:0]      core_c_in,
  output logic [7:0]            core_m,
  input  logic                  core_hash_ready,
  input  logic [DIG_W-1:0]      core_digest
);

  // state   | meaning
  // IDLE    | no owner, arbitrating on req
  // LOAD    | latch owner's length onto the core, clear byte counter
  // STREAM  | forward owner's bytes until len accepted
  // WAIT    | last byte in flight, then wait for hash_ready
  // FLUSH   | (timeout build) zero-fill remaining bytes, drain core
  // DONE    | one-cycle done/err pulse, advance rr pointer

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef HASH_ARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_WAIT, S_FLUSH, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_WAIT, S_DONE
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         m_q, m_d;
  logic               mv_q, mv_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic               wfirst_q, wfirst_d;
`ifdef HASH_ARB_TIMEOUT_EN
  logic [ST_W-1:0]    stall_q, stall_d;
  logic               abort_q, abort_d;
`endif

  logic [LEN_W-1:0]   len_arr  [NREQ];
  logic [7:0]         byte_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign len_arr[k]  = req_len[k*LEN_W +: LEN_W];
    assign byte_arr[k] = req_byte[k*8 +: 8];
  end

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // First requester at or after the rotating pointer, wrapping.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr_q) + i) % NREQ;
      if (!pick_found && req[IDX_W'(j)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  logic ready_own;
  logic acc;

  assign ready_own  = (state_q == S_STREAM) && (cnt_q < len_q);
  assign acc        = ready_own && req_byte_valid[owner_q];
  assign byte_ready = ready_own ? grant_q : '0;
  assign grant      = grant_q;
  assign busy       = (state_q != S_IDLE);
  assign digest_out = dig_q;
  assign core_m_valid = mv_q;
  assign core_c_in  = len_q;
  assign core_m     = m_q;

`ifdef HASH_ARB_TIMEOUT_EN
  assign done = ((state_q == S_DONE) && !abort_q) ? grant_q : '0;
  assign err  = ((state_q == S_DONE) &&  abort_q) ? grant_q : '0;
`else
  assign done = (state_q == S_DONE) ? grant_q : '0;
  assign err  = '0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    m_d      = m_q;
    mv_d     = 1'b0;
    dig_d    = dig_q;
    wfirst_d = wfirst_q;
`ifdef HASH_ARB_TIMEOUT_EN
    abort_d  = abort_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = S_LOAD;
        end
      end

      S_LOAD: begin
        len_d = len_arr[owner_q];
        cnt_d = '0;
        if (len_arr[owner_q] == '0) begin
          dig_d   = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (acc) begin
          m_d   = byte_arr[owner_q];
          mv_d  = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) begin
            wfirst_d = 1'b1;
            state_d  = S_WAIT;
          end
        end
`ifdef HASH_ARB_TIMEOUT_EN
        else if (stall_q == ST_W'(TIMEOUT - 1)) begin
          wfirst_d = 1'b0;
          state_d  = S_FLUSH;
        end
`endif
      end

      S_WAIT: begin
        // The core may still show hash_ready from the previous message
        // until it sees the final M_valid, so skip the first cycle.
        if (wfirst_q) begin
          wfirst_d = 1'b0;
        end else if (core_hash_ready) begin
          dig_d   = core_digest;
          state_d = S_DONE;
        end
`ifdef HASH_ARB_TIMEOUT_EN
        else if (stall_q == ST_W'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end

`ifdef HASH_ARB_TIMEOUT_EN
      S_FLUSH: begin
        if (cnt_q != len_q) begin
          m_d   = 8'h00;
          mv_d  = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) wfirst_d = 1'b1;
        end else if (wfirst_q) begin
          wfirst_d = 1'b0;
        end else if (core_hash_ready) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        grant_d = '0;
        ptr_d   = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d = S_IDLE;
`ifdef HASH_ARB_TIMEOUT_EN
        abort_d = 1'b0;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef HASH_ARB_TIMEOUT_EN
  always_comb begin
    stall_d = stall_q;
    if ((state_d != state_q) || acc)
      stall_d = '0;
    else if (((state_q == S_STREAM) || (state_q == S_WAIT)) && (stall_q != ST_W'(TIMEOUT)))
      stall_d = stall_q + ST_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      m_q      <= '0;
      mv_q     <= 1'b0;
      dig_q    <= '0;
      wfirst_q <= 1'b0;
`ifdef HASH_ARB_TIMEOUT_EN
      stall_q  <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      m_q      <= m_d;
      mv_q     <= mv_d;
      dig_q    <= dig_d;
      wfirst_q <= wfirst_d;
`ifdef HASH_ARB_TIMEOUT_EN
      stall_q  <= stall_d;
      abort_q  <= abort_d;
`endif
    end
  end

endmodule

// File: doc/hash_arbiter.md
Name: hash_arbiter

Overview:
- Round-robin scheduler sharing one fullHashDES byte-stream hash core between NREQ requesters.
- Per message: grants one requester, loads the message length onto the core, forwards the requester's bytes with flow control, waits for hash_ready, returns the digest to that requester.
- Sits between the requester-side message sources and the single fullHashDES instance.

Parameters:
NREQ, 2, number of requesters (2..8)
LEN_W, 64, message-length width (core C_in width)
DIG_W, 32, digest width
TIMEOUT, 1024, stall limit in cycles (used only with HASH_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  request per requester, level
req_len  in  NREQ*LEN_W  message length in bytes, slice k for requester k
req_byte  in  NREQ*8  message byte, slice k
req_byte_valid  in  NREQ  byte valid per requester
byte_ready  out  NREQ  byte accepted this cycle when valid&ready
grant  out  NREQ  one-hot owner of the core, 0 when idle
done  out  NREQ  one-cycle pulse to owner, digest_out valid
digest_out  out  DIG_W  last digest, held until next done
busy  out  1  state != IDLE
err  out  NREQ  one-cycle abort pulse (0 unless HASH_ARB_TIMEOUT_EN)
core_m_valid  out  1  to core M_valid
core_c_in  out  LEN_W  to core C_in
core_m  out  8  to core M
core_hash_ready  in  1  from core hash_ready
core_digest  in  DIG_W  from core digest

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, rr pointer 0, byte counter 0.
- States: IDLE, LOAD, STREAM, WAIT, FLUSH (optional), DONE.
- IDLE: when any req is high, pick the first requester at or after pointer (wrapping); set grant one-hot; go to LOAD.
- Requesters not granted see byte_ready=0.
- LOAD (1 cycle):
  - Latch req_len slice of the owner into core_c_in; it stays stable until the next LOAD.
  - Clear counter.
  - len==0 → DONE with digest_out=0 and no core activity; else → STREAM.
- STREAM:
  - byte_ready[owner] = 1 while count < len.
  - On valid&ready, register the byte into core_m with core_m_valid=1 the next cycle (1-cycle latency) and increment count.
  - Otherwise core_m_valid=0 and core_m holds its value.
  - Accepting byte number len → WAIT.
- WAIT:
  - core_hash_ready is ignored in the first WAIT cycle (last byte still in flight; core drops stale hash_ready on M_valid).
  - From the second cycle, core_hash_ready=1 → capture core_digest into digest_out → DONE.
- DONE (1 cycle):
  - done[owner]=1.
  - Next cycle: grant=0, pointer=(owner+1) mod NREQ, go to IDLE.
- Back-to-back: a new grant is possible the cycle after DONE exits; a requester still holding req wins only if no other requester lies ahead of it on the rotating pointer.
- Owner deasserting req mid-message: ignored; the message runs to completion.
- req_len changes after LOAD: ignored.
- Counter width LEN_W; no wrap, since count never exceeds len.
- byte_ready is a combinational function of state/count/grant only; it does not depend on req_byte_valid.

Optional Feature:
- HASH_ARB_TIMEOUT_EN defined:
  - A stall counter clears on every accepted byte and on state entry.
  - STREAM stalled for TIMEOUT cycles → FLUSH.
  - FLUSH: drives core_m=8'h00, core_m_valid=1 for each remaining byte until count==len, then waits for core_hash_ready and discards the digest (digest_out unchanged). Then err[owner] pulses for one cycle, done stays 0, and the pointer advances as in DONE.
  - WAIT stalled for TIMEOUT cycles → err pulse, return to IDLE via the same pointer advance.
- HASH_ARB_TIMEOUT_EN not defined: no stall counter, no FLUSH state, err tied 0, and the controller waits indefinitely.

Test Plan:
- Single message: req[0], len=50, bytes 0..49 streamed every cycle → core sees C_in=50 and exactly 50 M_valid pulses with M=0..49 in order; done[0] pulses once; digest_out equals core_digest; grant returns to 0.
- Contention: req=2'b11 right after reset → requester 0 served first, then 1. Both then re-request → 1 is not served twice in a row; order is 0,1,0.
- Gappy source: len=8, req_byte_valid toggling 1,0,0,1,… → exactly 8 core_m_valid pulses with bytes in order and no duplicates; core_c_in stable throughout.
- Zero length: len=0 → done pulses within 3 cycles of grant; digest_out=0; core_m_valid never asserted.
- Reset mid-stream: rst_n low after 10 of 50 bytes → all outputs 0 immediately; a following len=4 request completes normally with done.
- (HASH_ARB_TIMEOUT_EN, TIMEOUT=16) Stall after 10 of 50 bytes → after 16 cycles, 40 bytes of 0x00 reach the core; err[0] pulses after hash_ready; done stays 0; digest_out unchanged.
